// File: rtl/capture_write_ctrl.sv
// ---------------------------------------------------------------------------
// capture_write_ctrl
//
// Write-side controller for the capture buffer.  Qualified samples are streamed
// into port A of the dual-port capture RAM as a circular buffer.  A programmable
// amount of pre-trigger history is kept.  After a trigger the controller fills
// the rest of the buffer, stops, and reports where the capture window begins.
// Readout logic drains the RAM through port B once done is high.
//
// Parameters
//   DATA_WIDTH   sample width, equal to the RAM data width
//   MEM_DEPTH    RAM depth in samples (power of two, >= 4)
//
// Ports
//   clk           single clock for all logic and RAM port A
//   rst           synchronous, active-high reset
//   arm           1-cycle pulse, starts a capture from IDLE or DONE
//   pre_trig_len  pre-trigger samples to keep, sampled when arm is accepted
//   din_valid     sample qualifier
//   din           sample data
//   trigger       trigger, only honoured together with din_valid
//   ram_wr        RAM port A write enable (registered, one pulse per sample)
//   ram_addr      RAM port A address (registered)
//   ram_din       RAM port A write data (registered)
//   busy          high while a capture is in progress
//   done          high once the window is complete
//   start_addr    RAM address of the oldest sample in the window
//   trig_addr     RAM address of the trigger sample
// ---------------------------------------------------------------------------
module capture_write_ctrl #(
    parameter  int DATA_WIDTH = 64,
    parameter  int MEM_DEPTH  = 128,
    localparam int AW         = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic [AW-1:0]         pre_trig_len,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  trigger,
    output logic                  ram_wr,
    output logic [AW-1:0]         ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  busy,
    output logic                  done,
    output logic [AW-1:0]         start_addr,
    output logic [AW-1:0]         trig_addr
);

    // Highest RAM index; the number of post-trigger samples is this minus P.
    localparam logic [AW-1:0] LAST_IDX = AW'(MEM_DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRETRIG,
        ST_WAIT_TRIG,
        ST_POST,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   pre_cnt;
    logic [AW-1:0]   p_len;
    logic [AW-1:0]   post_cnt;

    logic            capturing;
    logic            accept;
    logic            arm_ok;
    logic            trig_hit;
    logic            pre_full;
    logic            post_last;
    logic [AW-1:0]   post_len;

    // Qualifiers shared by the FSM and the datapath.  A sample is only ever
    // written while a capture is running; arm is only honoured when idle or
    // finished.  pre_full looks ahead one sample so the state moves on in the
    // same cycle the P-th history sample is taken.
    always_comb begin
        capturing = (state == ST_PRETRIG) || (state == ST_WAIT_TRIG) || (state == ST_POST);
        accept    = capturing && din_valid;
        arm_ok    = arm && ((state == ST_IDLE) || (state == ST_DONE));
        trig_hit  = (state == ST_WAIT_TRIG) && din_valid && trigger;
        pre_full  = (pre_cnt + 1'b1) == p_len;
        post_last = post_cnt == AW'(1);
        post_len  = LAST_IDX - p_len;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.  With P=0 there is no history to collect, so arm goes
    // straight to waiting for the trigger.  When P=MEM_DEPTH-1 the trigger
    // sample is itself the last one of the window and POST is skipped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_nxt = (pre_trig_len == '0) ? ST_WAIT_TRIG : ST_PRETRIG;
                end
            end
            ST_PRETRIG: begin
                if (din_valid && pre_full) begin
                    state_nxt = ST_WAIT_TRIG;
                end
            end
            ST_WAIT_TRIG: begin
                if (trig_hit) begin
                    state_nxt = (post_len == '0) ? ST_DONE : ST_POST;
                end
            end
            ST_POST: begin
                if (din_valid && post_last) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state register.  Because the final
    // sample moves the FSM to DONE on the same edge that registers its RAM
    // write, done rises together with the last ram_wr pulse.
    always_comb begin
        busy = capturing;
        done = (state == ST_DONE);
    end

    // Write pointer and history counter.  The pointer wraps naturally at
    // MEM_DEPTH because it is exactly AW bits wide.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            pre_cnt <= '0;
            p_len   <= '0;
        end else begin
            if (arm_ok) begin
                wr_ptr  <= '0;
                pre_cnt <= '0;
                p_len   <= pre_trig_len;
            end else if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if ((state == ST_PRETRIG) && din_valid) begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

    // Trigger bookkeeping.  The window start is P samples behind the trigger,
    // modulo the depth; the AW-bit subtraction provides the wrap.  The
    // addresses are left alone on arm and only change at the next trigger.
    always_ff @(posedge clk) begin
        if (rst) begin
            trig_addr  <= '0;
            start_addr <= '0;
            post_cnt   <= '0;
        end else begin
            if (trig_hit) begin
                trig_addr  <= wr_ptr;
                start_addr <= wr_ptr - p_len;
                post_cnt   <= post_len;
            end else if ((state == ST_POST) && din_valid) begin
                post_cnt <= post_cnt - 1'b1;
            end
        end
    end

    // Registered RAM port A.  The write enable is a single-cycle pulse per
    // accepted sample; address and data hold their last values in between.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else begin
            ram_wr <= accept;
            if (accept) begin
                ram_addr <= wr_ptr;
                ram_din  <= din;
            end
        end
    end

endmodule
